// File: rtl/rca_seq_adder_ctrl.sv
// Wide add/subtract sequencer: one shared 4-bit ripple-carry adder is stepped over
// NIBBLES slices, LSB first, with the inter-nibble carry held in a register.

module rca4 (
    input  logic [3:0] i0,
    input  logic [3:0] i1,
    input  logic       cin,
    output logic [3:0] o,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign o[i]     = i0[i] ^ i1[i] ^ c[i];
        assign c[i + 1] = (i0[i] & i1[i]) | (c[i] & (i0[i] ^ i1[i]));
    end

    assign cout = c[4];
endmodule

module rca_seq_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [CNT_W-1:0] k;
    logic             accept;
    logic             last;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       rca_o;
    logic             rca_co;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (k == CNT_W'(NIBBLES - 1));

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == CNT_W'(i)) begin
                nib_a = a_reg[4*i +: 4];
                nib_b = b_reg[4*i +: 4];
            end
        end
    end

    rca4 u_rca (
        .i0   (nib_a),
        .i1   (nib_b),
        .cin  (carry),
        .o    (rca_o),
        .cout (rca_co)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction is folded into the operands at accept: a - b - cin == a + ~b + ~cin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            k     <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k == CNT_W'(i)) begin
                    sum[4*i +: 4] <= rca_o;
                end
            end
            carry <= rca_co;
            k     <= last ? '0 : k + CNT_W'(1);
            if (last) begin
                cout <= rca_co;
                ovf  <= (a_reg[W-1] == b_reg[W-1]) && (rca_o[3] != a_reg[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Directed-vector bench for rca_seq_adder_ctrl with NIBBLES=4 (16-bit operands).

module tb_rca_seq_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests;
    int fails;

    rca_seq_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse at a negedge, then follow the op until done (bounded).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv,
                          output int busy_cycles, output logic got_done);
        int n;
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            n++;
        end
        got_done = done;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, cout, ovf} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags busy/done/cout/ovf got %b want 0000", {busy, done, cout, ovf});
        end
        tests++;
        if (sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_sum got %h want 0000", sum);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        int bc; logic gd;
        run_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, bc, gd);
        tests++;
        if (gd !== 1'b1 || bc != 4) begin
            fails++;
            $display("FAIL basic_timing done=%b busy_cycles=%0d want done=1 busy_cycles=4", gd, bc);
        end
        tests++;
        if ({sum, cout, ovf} !== {16'h2143, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_add sum=%h cout=%b ovf=%b want 2143/0/0", sum, cout, ovf);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h2143) begin
            fails++;
            $display("FAIL basic_hold done=%b busy=%b sum=%h want 0/0/2143", done, busy, sum);
        end
    endtask

    task automatic test_ripple();
        int bc; logic gd;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL ripple done=%b sum=%h cout=%b ovf=%b want 1/0000/1/0", gd, sum, cout, ovf);
        end
    endtask

    task automatic test_overflow();
        int bc; logic gd;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL ovf_add done=%b sum=%h cout=%b ovf=%b want 1/8000/0/1", gd, sum, cout, ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL ovf_sub done=%b sum=%h cout=%b ovf=%b want 1/7fff/1/1", gd, sum, cout, ovf);
        end
    endtask

    task automatic test_subtract();
        int bc; logic gd;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sub_borrow done=%b sum=%h cout=%b ovf=%b want 1/fffe/0/0", gd, sum, cout, ovf);
        end
        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout, ovf} !== {16'h000E, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_cin done=%b sum=%h cout=%b ovf=%b want 1/000e/1/0", gd, sum, cout, ovf);
        end
        run_op(16'h1234, 16'h0F0F, 1'b1, 1'b0, bc, gd);
        tests++;
        if (gd !== 1'b1 || {sum, cout} !== {16'h2144, 1'b0}) begin
            fails++;
            $display("FAIL add_cin done=%b sum=%h cout=%b want 1/2144/0", gd, sum, cout);
        end
    endtask

    task automatic test_start_ignored();
        int n; int bc;
        @(negedge clk);
        a = 16'h1234; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1 || n != 2 || {sum, cout, ovf} !== {16'h2143, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL ignore_start done=%b extra_cycles=%0d sum=%h cout=%b ovf=%b want 1/2/2143/0/0",
                     done, n, sum, cout, ovf);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_restart busy=%b done=%b want 0/0", busy, done);
        end
        bc = 0;
    endtask

    task automatic test_back_to_back();
        int n; int bc;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first done=%b sum=%h cout=%b want 1/0000/1", done, sum, cout);
        end
        a = 16'h0005; b = 16'h0003; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_idle busy=%b done=%b want 1/0", busy, done);
        end
        bc = 0; n = 0;
        while (!done && n < 20) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1 || bc != 4 || sum !== 16'h0008 || cout !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second done=%b busy_cycles=%0d sum=%h cout=%b want 1/4/0008/0", done, bc, sum, cout);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc; int n; logic gd; logic saw_done;
        @(negedge clk);
        a = 16'h1234; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || sum[7:0] !== 8'h43) begin
            fails++;
            $display("FAIL mid_run_partial busy=%b sum=%h want 1/xx43", busy, sum);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, done, cout, ovf} !== 4'b0000 || sum !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset busy=%b done=%b cout=%b ovf=%b sum=%h want 0/0/0/0/0000",
                     busy, done, cout, ovf, sum);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_no_done activity=%b want 0", saw_done);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, bc, gd);
        tests++;
        if (gd !== 1'b1 || bc != 4 || {sum, cout, ovf} !== {16'h0100, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL after_reset done=%b busy_cycles=%0d sum=%h cout=%b ovf=%b want 1/4/0100/0/0",
                     gd, bc, sum, cout, ovf);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_add();
        test_ripple();
        test_overflow();
        test_subtract();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rca_seq_adder_ctrl.md
Name: rca_seq_adder_ctrl

Overview:
- Sequencer that performs wide add/subtract on operands of 4*NIBBLES bits using one shared 4-bit RCA instance, one nibble per clock, LSB nibble first.
- The carry is registered between nibbles.
- Sits between a requesting unit (start/done handshake) and the existing 4-bit RCA datapath (ports i0, i1, cin, o, cout), which it instantiates internally.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (W = 4*NIBBLES); legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request pulse; sampled only when the block can accept.
- a  input  W  operand A; captured on an accepted start.
- b  input  W  operand B; captured on an accepted start.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on an accepted start.
- sub  input  1  0 = a+b+cin, 1 = a-b-cin; captured on an accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  W  result; held stable from done until the next accepted start.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow of the W-bit result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, nibble counter=0, carry reg=0.
  - Operand regs = 0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
- States: IDLE, RUN, DONE. Encoding is free.
- Accept condition: start=1 at a rising edge with state IDLE or DONE.
  - On accept: latch a; latch b_eff = sub ? ~b : b; carry reg = sub ? ~cin : cin.
  - Also on accept: counter=0, sum cleared to 0, state=RUN.
  - start while in RUN is ignored, with no side effects.
- RUN: RCA is driven combinationally with i0 = a nibble[k], i1 = b_eff nibble[k], cin = carry reg.
  - Each edge: sum nibble[k] <= o, carry reg <= RCA cout, k <= k+1.
  - When k == NIBBLES-1 at the edge:
    - cout <= RCA cout.
    - ovf <= (a[W-1] == b_eff[W-1]) && (o[3] != a[W-1]).
    - state <= DONE.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - Next state is RUN if start is accepted, otherwise IDLE.
- Outputs:
  - busy = (state == RUN), registered via state.
  - done = (state == DONE).
  - sum, cout and ovf are registers.
- Latency: start is accepted at edge E0; nibble k is processed at edge E(k+1); done is high during the cycle following edge E(NIBBLES).
  - Request-to-done is NIBBLES cycles.
  - Back-to-back throughput is one operation per NIBBLES+1 cycles.
- Intermediate sum nibbles may be observed mid-RUN. Only the sum value while done=1 is architecturally valid.
- Operand changes on a/b/cin/sub after accept have no effect.
- Wrap-around: the result is modulo 2^W; the carry out of the top nibble goes only to cout.
- Reset asserted mid-RUN aborts the operation. No done is issued, all outputs return to reset values, and the next start after release operates normally.
- start coincident with reset deassertion edge: not accepted. Sampling begins on the first edge with reset=1.

Test Plan:
- Basic add, NIBBLES=4: a=0x1234, b=0x0F0F, cin=0, sub=0, start 1 cycle.
  - Expect busy high 4 cycles, then done pulse.
  - Expect sum=0x2143, cout=0, ovf=0.
- Full carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0.
  - Then a=0x0010, b=0x0001, sub=1, cin=1 → sum=0x000E, cout=1.
- Handshake robustness:
  - Pulse start during RUN with different operands → ignored; result is the first operation's.
  - Assert start during the DONE cycle → new operation starts with no IDLE cycle; its done arrives 4 cycles later.
- Reset mid-operation: drop reset after the 2nd nibble of 0x1234+0x0F0F.
  - Expect sum=0, busy=0, no done.
  - After release, 0x00FF+0x0001 → sum=0x0100, done after 4 cycles.
